// File: rtl/rotary_pkg.sv
// Shared rotary-encoder definitions: FSM encoding, Gray tables and the step request payload.
// Also used by the quadrature decoder so both ends agree on phase order.
package rotary_pkg;

   localparam int unsigned PHASE_IDX_W = 2;

   typedef logic [PHASE_IDX_W-1:0] phase_idx_t;

   // Quadrature level packed as {a, b}
   typedef logic [1:0] quad_t;

   localparam quad_t GRAY_IDLE = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDGE   = 2'd1,
      ST_BOUNCE = 2'd2,
      ST_HOLD   = 2'd3
   } rot_state_e;

   typedef struct packed {
      logic dir_cw;
      logic bounce;
   } step_req_t;

   // Target level after phase idx: CW 10,11,01,00 ; CCW 01,11,10,00
   function automatic quad_t gray_code(input logic dir_cw, input phase_idx_t idx);
      quad_t code;
      unique case (idx)
         2'd0:    code = dir_cw ? 2'b10 : 2'b01;
         2'd1:    code = 2'b11;
         2'd2:    code = dir_cw ? 2'b01 : 2'b10;
         default: code = GRAY_IDLE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expire_c marks the N-th cycle after a load of N,
// near_c the cycle just before it.
module cycle_timer #(
   parameter int unsigned W = 8
) (
   input  logic         aclk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         expire_c,
   output logic         near_c
);

   logic [W-1:0] cnt_q, cnt_d;

   always_ff @(posedge aclk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)              cnt_d = load_val_i;
      else if (cnt_q != W'(0)) cnt_d = cnt_q - W'(1);
   end

   assign expire_c = (cnt_q == W'(1));
   assign near_c   = (cnt_q == W'(2));

endmodule

// File: rtl/quad_step_gen.sv
// Encoder emulator: each accepted step plays one full Gray cycle on a_out/b_out,
// optionally with contact bounce after every edge, and tracks a wrapping position.
module quad_step_gen
   import rotary_pkg::*;
#(
   parameter int unsigned PHASE_CYCLES  = 1000,
   parameter int unsigned BOUNCE_CYCLES = 100,
   parameter int unsigned BOUNCE_TOGGLE = 2,
   parameter int unsigned POS_W         = 16
) (
   input  logic             aclk,
   input  logic             reset,
   input  logic             step_valid,
   input  logic             step_dir,
   input  logic             bounce_en,
   output logic             step_ready,
   output logic             a_out,
   output logic             b_out,
   output logic             busy,
   output logic [POS_W-1:0] position
);

   localparam int unsigned TMAX = (PHASE_CYCLES > BOUNCE_CYCLES) ? PHASE_CYCLES : BOUNCE_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   rot_state_e       state_q, state_d;
   step_req_t        req_q, req_d;
   phase_idx_t       phase_q, phase_d;
   quad_t            ab_q, ab_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;

   logic             ph_load, ph_exp, ph_near;
   logic [TW-1:0]    ph_val;
   logic             tg_load, tg_exp, tg_near_unused;
   quad_t            tgt, mov;

   // Phase timer paces BOUNCE and HOLD; toggle timer paces bounce flips
   cycle_timer #(.W(TW)) u_phase_tmr (
      .aclk       (aclk),
      .reset      (reset),
      .load_i     (ph_load),
      .load_val_i (ph_val),
      .expire_c   (ph_exp),
      .near_c     (ph_near)
   );

   cycle_timer #(.W(TW)) u_toggle_tmr (
      .aclk       (aclk),
      .reset      (reset),
      .load_i     (tg_load),
      .load_val_i (TW'(BOUNCE_TOGGLE)),
      .expire_c   (tg_exp),
      .near_c     (tg_near_unused)
   );

   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         phase_q <= '0;
         ab_q    <= GRAY_IDLE;
         pos_q   <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         phase_q <= phase_d;
         ab_q    <= ab_d;
         pos_q   <= pos_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      phase_d = phase_q;
      ab_d    = ab_q;
      pos_d   = pos_q;
      ready_d = ready_q;
      ph_load = 1'b0;
      ph_val  = TW'(PHASE_CYCLES);
      tg_load = 1'b0;

      // Only the bit that moves in this phase may bounce
      tgt = gray_code(req_q.dir_cw, phase_q);
      mov = tgt ^ gray_code(req_q.dir_cw, phase_idx_t'(phase_q - PHASE_IDX_W'(1)));

      unique case (state_q)
         ST_IDLE: begin
            if (step_valid) begin
               req_d   = '{dir_cw: step_dir, bounce: bounce_en};
               phase_d = '0;
               ab_d    = gray_code(step_dir, '0);
               tg_load = 1'b1;
               ready_d = 1'b0;
               state_d = ST_EDGE;
            end
         end
         ST_EDGE: begin
            ph_load = 1'b1;
            if (req_q.bounce) begin
               ph_val  = TW'(BOUNCE_CYCLES);
               tg_load = tg_exp;
               if (tg_exp) ab_d = ab_q ^ mov;
               state_d = ST_BOUNCE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_BOUNCE: begin
            tg_load = tg_exp;
            if (ph_exp) begin
               ph_load = 1'b1;
               state_d = ST_HOLD;
            end else if (ph_near) begin
               ab_d = tgt;
            end else if (tg_exp) begin
               ab_d = ab_q ^ mov;
            end
         end
         ST_HOLD: begin
            if (ph_exp) begin
               if (phase_q == PHASE_IDX_W'(3)) begin
                  pos_d   = req_q.dir_cw ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                  ready_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  phase_d = phase_idx_t'(phase_q + PHASE_IDX_W'(1));
                  ab_d    = gray_code(req_q.dir_cw, phase_idx_t'(phase_q + PHASE_IDX_W'(1)));
                  tg_load = 1'b1;
                  state_d = ST_EDGE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = ~ready_d;
   end

   assign step_ready = ready_q;
   assign busy       = busy_q;
   assign a_out      = ab_q[1];
   assign b_out      = ab_q[0];
   assign position   = pos_q;

endmodule
